// File: rtl/instruction_mem_loader.sv
// Instruction memory and program loader: assembles little-endian words from a UART byte
// stream until HALT, pulses the PC start flag, then serves combinational fetches in RUN.
module instruction_mem_loader #(
    parameter int          SIZE_ADDR_PC = 32,
    parameter int          MEM_DEPTH    = 256,
    parameter logic [31:0] HALT_CODE    = 32'hFFFFFFFF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_load_req,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_valid,
    input  logic [SIZE_ADDR_PC-1:0]       i_fetch_addr,
    output logic [31:0]                   o_instruction,
    output logic                          o_flag_start_pc,
    output logic                          o_loading,
    output logic [$clog2(MEM_DEPTH):0]    o_word_count,
    output logic                          o_error,
    output logic [2:0]                    o_dbg_state
);

    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int WC_W = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic [WC_W-1:0]   word_cnt_q;
    logic              loading_q;
    logic              start_q;
    logic              error_q;
    logic              word_wr;
    logic [31:0]       mem_q [MEM_DEPTH];

    // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
    assign asm_d   = {i_rx_data, asm_q[31:8]};
    assign word_wr = (state_q == S_LOAD) && i_rx_valid && (byte_cnt_q == 2'd3);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'h0;
            word_cnt_q <= '0;
            loading_q  <= 1'b0;
            start_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (i_load_req) begin
                        state_q    <= S_LOAD;
                        byte_cnt_q <= 2'd0;
                        asm_q      <= 32'h0;
                        word_cnt_q <= '0;
                        loading_q  <= 1'b1;
                        error_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (i_rx_valid) begin
                        asm_q <= asm_d;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q <= 2'd0;
                            word_cnt_q <= word_cnt_q + WC_W'(1);
                            // HALT wins even when it is the word that fills the memory.
                            if (asm_d == HALT_CODE) begin
                                state_q   <= S_START;
                                loading_q <= 1'b0;
                                start_q   <= 1'b1;
                            end else if (word_cnt_q == WC_W'(MEM_DEPTH - 1)) begin
                                state_q   <= S_ERROR;
                                loading_q <= 1'b0;
                                error_q   <= 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_RUN;
                    start_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    loading_q <= 1'b0;
                    start_q   <= 1'b0;
                    error_q   <= 1'b0;
                end
            endcase
        end
    end

    // Memory is never cleared; stale words are hidden by the word count on the read side.
    always_ff @(posedge i_clk) begin
        if (word_wr) begin
            mem_q[word_cnt_q[AW-1:0]] <= asm_d;
        end
    end

    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic          fetch_unused;

    assign rd_idx       = i_fetch_addr[AW+1:2];
    assign rd_in_range  = ((i_fetch_addr >> (AW + 2)) == '0);
    assign fetch_unused = &i_fetch_addr[1:0];

    assign o_instruction   = ((state_q == S_RUN) && rd_in_range && ({1'b0, rd_idx} < word_cnt_q))
                             ? mem_q[rd_idx] : 32'h0;
    assign o_flag_start_pc = start_q;
    assign o_loading       = loading_q;
    assign o_word_count    = word_cnt_q;
    assign o_error         = error_q;
    assign o_dbg_state     = state_q;

endmodule

// File: doc/instruction_mem_loader.md
# instruction_mem_loader

Instruction memory and program loader for the fetch stage, sitting directly upstream of the PC block. It receives the program as a byte stream from the UART receiver and assembles little-endian 32-bit words into an internal instruction memory. When it detects the HALT code it pulses the PC's start flag. Afterwards it serves combinational instruction reads at the byte address driven by the PC.

## Interface
- SIZE_ADDR_PC, 32, width of fetch address.
- MEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2, ≥4).
- HALT_CODE, 32'hFFFFFFFF, word that terminates a program load.

Ports:
- i_clk  in  1  single clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_load_req  in  1  one-cycle request to start loading a new program.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  i_rx_data valid this cycle (single-cycle strobe per byte).
- i_fetch_addr  in  SIZE_ADDR_PC  byte address from PC.
- o_instruction  out  32  instruction at i_fetch_addr (combinational).
- o_flag_start_pc  out  1  one-cycle pulse: program loaded, PC may run.
- o_loading  out  1  high while in LOAD.
- o_word_count  out  $clog2(MEM_DEPTH)+1  words written in current/last load, HALT word included.
- o_error  out  1  memory filled without HALT.

## Operation
- FSM states: IDLE, LOAD, START, RUN, ERROR.
- IDLE:
  - i_load_req → LOAD.
  - Clears byte counter and word counter on entry to LOAD.
- LOAD:
  - Each i_rx_valid byte is shifted into the assembly register.
  - Byte order is little-endian: the 1st byte lands in [7:0] and the 4th byte in [31:24].
  - On the 4th byte, the assembled word is written to mem[word_count], word_count increments, and the byte counter returns to 0.
  - If the assembled word == HALT_CODE → START.
  - Otherwise, if word_count reaches MEM_DEPTH after this write → ERROR.
  - i_load_req is ignored in LOAD.
- START: o_flag_start_pc=1 for exactly this one cycle → RUN.
- RUN: i_rx_valid is ignored; i_load_req → LOAD, which clears the counters.
- ERROR:
  - o_error=1.
  - i_load_req → LOAD and clears o_error.
  - i_rx_valid is ignored.
- Read path:
  - Word index = i_fetch_addr[$clog2(MEM_DEPTH)+1:2]. Bits [1:0] are ignored.
  - o_instruction = mem[index] only in RUN and only when index < o_word_count.
  - o_instruction = 32'h0 (NOP) otherwise, which covers any other state, unloaded words, and i_fetch_addr ≥ 4·MEM_DEPTH.
- Memory contents are not cleared by reset or reload. Stale words are masked by o_word_count.
- Partial word at reset or reload is discarded.

## Timing
- Reset values (i_reset=0 at an edge):
  - State is IDLE.
  - o_flag_start_pc=0, o_loading=0, o_word_count=0, o_error=0, byte counter=0, assembly register=0.
  - o_instruction=0.
- Reset overrides all other inputs, including mid-load.
- Load request:
  - i_load_req sampled at edge N → o_loading=1 from N.
  - A byte presented in the same cycle as i_load_req is not captured.
- Write latency: the 4th byte sampled at edge N → word visible in mem and o_word_count updated after edge N.
- HALT: the 4th byte of HALT at edge N → o_flag_start_pc high during cycle N..N+1; RUN from edge N+1.
- Reads:
  - Reads are zero-latency combinational from i_fetch_addr.
  - The first valid fetch is in the cycle after the start pulse.
- Overflow: the 4th byte of word MEM_DEPTH-1 (non-HALT) at edge N → o_error=1 and o_loading=0 after N.
- Back-to-back bytes on every cycle must be accepted without loss.

## Test plan
- Reset, load request, bytes 13,00,00,20 | FF,FF,FF,FF:
  - o_word_count=2 and a single start pulse.
  - In RUN, fetch 0x0 → 0x20000013; fetch 0x4 → 0xFFFFFFFF; fetch 0x8 → 0x0.
- Byte ordering: bytes 78,56,34,12 then HALT → fetch 0x0 = 0x12345678; fetch 0x2 (unaligned) also 0x12345678.
- MEM_DEPTH=4, load four non-HALT words → o_error=1 after the 16th byte, no start pulse, fetch returns 0; then i_load_req clears o_error.
- Reset asserted after 6 bytes of a load → all outputs 0, state IDLE; a fresh load of 1 word + HALT behaves as in test 1 with o_word_count=2.
- Reload in RUN with a shorter program (HALT only) → o_word_count=1; fetch 0x4 returns 0 despite stale memory contents.
- Bytes with i_rx_valid in IDLE/RUN and i_load_req during LOAD → ignored; counters and contents unchanged.
